// File: rtl/fetch_unit_pkg.sv
// Shared pipeline types: IF/ID register layout and fetch defaults.
package fetch_unit_pkg;

  localparam int unsigned FETCH_PC_W    = 9;
  localparam int unsigned FETCH_INSTR_W = 32;
  localparam int unsigned FETCH_PC_STEP = 4;
  localparam logic [FETCH_PC_W-1:0] FETCH_RESET_PC = '0;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]    curr_pc;
    logic [FETCH_INSTR_W-1:0] curr_instr;
  } if_id_reg;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel (one outstanding request).
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic                     req;
  logic [FETCH_PC_W-1:0]    addr;
  logic                     rvalid;
  logic [FETCH_INSTR_W-1:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} buffer that absorbs a response arriving under stall.
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     drain,
  input  logic     clear,
  input  if_id_reg din,
  output if_id_reg dout,
  output logic     full
);

  // Drain and clear both empty the entry; load only when not emptying.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (drain || clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues imem requests and writes the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned             PC_STEP  = FETCH_PC_STEP,
  parameter logic [FETCH_PC_W-1:0]   RESET_PC = FETCH_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_unit_if.master          imem,
  input  logic                  redirect_valid,
  input  logic [FETCH_PC_W-1:0] redirect_pc,
  input  logic                  stall,
  input  logic                  halt_in,
  output if_id_reg              if_id_out,
  output logic                  if_id_valid,
  output logic                  fetch_halted
);

  localparam int unsigned PC_W = FETCH_PC_W;

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_HOLD    = 3'd2;
  localparam logic [2:0] ST_DISCARD = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  logic [2:0]      state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [PC_W-1:0] req_pc, req_pc_n;
  logic            halt_pending, halt_pending_n;
  if_id_reg        if_id_n;
  logic            valid_n;
  logic            req_c;
  logic            skid_load, skid_drain, skid_clear;
  logic            skid_full;
  if_id_reg        skid_q;
  if_id_reg        fetched;

  assign fetched   = {req_pc, imem.rdata};
  assign imem.addr = pc;
  assign imem.req  = req_c && rst_n;

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .drain (skid_drain),
    .clear (skid_clear),
    .din   (fetched),
    .dout  (skid_q),
    .full  (skid_full)
  );

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_FETCH;
      pc           <= RESET_PC;
      req_pc       <= RESET_PC;
      halt_pending <= 1'b0;
      if_id_out    <= '0;
      if_id_valid  <= 1'b0;
      fetch_halted <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      req_pc       <= req_pc_n;
      halt_pending <= halt_pending_n;
      if_id_out    <= if_id_n;
      if_id_valid  <= valid_n;
      fetch_halted <= (state_n == ST_HALT);
    end
  end

  // Next-state: redirect beats halt beats normal sequencing; HALT is terminal.
  always_comb begin
    state_n        = state;
    pc_n           = pc;
    req_pc_n       = req_pc;
    halt_pending_n = halt_pending;
    if_id_n        = if_id_out;
    valid_n        = stall ? if_id_valid : 1'b0;
    req_c          = 1'b0;
    skid_load      = 1'b0;
    skid_drain     = 1'b0;
    skid_clear     = 1'b0;

    if (state == ST_HALT) begin
      valid_n = 1'b0;
    end else if (redirect_valid) begin
      pc_n           = redirect_pc;
      skid_clear     = 1'b1;
      valid_n        = 1'b0;
      halt_pending_n = 1'b0;
      // A request still in flight must be swallowed before fetching again.
      if ((state == ST_WAIT || state == ST_DISCARD) && !imem.rvalid) begin
        state_n = ST_DISCARD;
      end else begin
        state_n = ST_FETCH;
      end
    end else if (halt_in) begin
      skid_clear = 1'b1;
      if ((state == ST_WAIT || state == ST_DISCARD) && !imem.rvalid) begin
        state_n        = ST_DISCARD;
        halt_pending_n = 1'b1;
      end else begin
        state_n        = ST_HALT;
        halt_pending_n = 1'b0;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          req_c    = 1'b1;
          req_pc_n = pc;
          pc_n     = pc + PC_W'(PC_STEP);
          state_n  = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem.rvalid) begin
            if (!stall) begin
              if_id_n = fetched;
              valid_n = 1'b1;
              state_n = ST_FETCH;
            end else begin
              skid_load = 1'b1;
              state_n   = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            if_id_n    = skid_q;
            valid_n    = skid_full;
            skid_drain = 1'b1;
            state_n    = ST_FETCH;
          end
        end
        ST_DISCARD: begin
          if (imem.rvalid) begin
            state_n        = halt_pending ? ST_HALT : ST_FETCH;
            halt_pending_n = 1'b0;
          end
        end
        default: state_n = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus randomized stream checking.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       redirect_valid, stall, halt_in;
  logic [8:0] redirect_pc;

  fetch_unit_if imem0();
  fetch_unit_if imem1();

  if_id_reg out0, out1;
  logic     valid0, valid1, halted0, halted1;

  int n_pass = 0, n_checks = 0, n_deliv = 0;
  int lat = 1, wcnt = 0;
  logic pend = 1'b0;
  logic [8:0] pa0, pa1, exp_pc;
  logic prev_stall = 1'b0, prev_redirect = 1'b0, prev_valid = 1'b0;
  if_id_reg prev_out = '0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_STEP(4), .RESET_PC(9'h000)) dut0 (
    .clk(clk), .rst_n(rst_n), .imem(imem0),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .halt_in(halt_in),
    .if_id_out(out0), .if_id_valid(valid0), .fetch_halted(halted0));

  fetch_unit #(.PC_STEP(4), .RESET_PC(9'h1F8)) dut1 (
    .clk(clk), .rst_n(rst_n), .imem(imem1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .halt_in(halt_in),
    .if_id_out(out1), .if_id_valid(valid1), .fetch_halted(halted1));

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    return 32'hC0DE_0000 ^ {a, 7'h13, ~a, 7'h05};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // One clock: drive inputs and the imem model at negedge, then check the stream.
  task automatic cyc(input logic st, input logic rd, input logic [8:0] rpc, input logic hl);
    logic rv;
    @(negedge clk);
    stall = st; redirect_valid = rd; redirect_pc = rpc; halt_in = hl;
    rv = 1'b0;
    imem0.rdata = $urandom;
    imem1.rdata = $urandom;
    if (pend) begin
      if (wcnt == 0) begin
        rv = 1'b1;
        pend = 1'b0;
        imem0.rdata = mem_word(pa0);
        imem1.rdata = mem_word(pa1);
      end else begin
        wcnt--;
      end
    end
    imem0.rvalid = rv;
    imem1.rvalid = rv;
    #1;
    if (prev_redirect) begin
      check("flush_bubble", 64'(valid0), 64'd0);
    end else if (prev_stall) begin
      check("stall_hold_data", 64'(out0), 64'(prev_out));
      check("stall_hold_valid", 64'(valid0), 64'(prev_valid));
    end else if (valid0) begin
      check("stream_pc", 64'(out0.curr_pc), 64'(exp_pc));
      check("stream_instr", 64'(out0.curr_instr), 64'(mem_word(out0.curr_pc)));
      exp_pc = exp_pc + 9'd4;
      n_deliv++;
    end
    if (imem0.req) begin
      check("one_outstanding", 64'(pend), 64'd0);
      pend = 1'b1;
      wcnt = lat - 1;
      pa0 = imem0.addr;
      pa1 = imem1.addr;
    end
    if (rd) exp_pc = rpc;
    prev_stall = st; prev_redirect = rd;
    prev_out = out0; prev_valid = valid0;
  endtask

  task automatic clear_model();
    pend = 1'b0; wcnt = 0;
    prev_stall = 1'b0; prev_redirect = 1'b0; prev_valid = 1'b0; prev_out = '0;
    exp_pc = 9'h000;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_in = 1'b0;
    imem0.rvalid = 1'b0; imem1.rvalid = 1'b0; imem0.rdata = '0; imem1.rdata = '0;
    clear_model();
    #1 rst_n = 1'b0;
    #2;
    check("rst_req", 64'(imem0.req), 64'd0);
    check("rst_valid", 64'(valid0), 64'd0);
    check("rst_out", 64'(out0), 64'd0);
    check("rst_halted", 64'(halted0), 64'd0);
    repeat (2) @(posedge clk);
    release_reset();

    // Sequential fetch with 1-cycle imem.
    cyc(0, 0, 0, 0);
    check("t1_req0", 64'(imem0.req), 64'd1);
    check("t1_addr0", 64'(imem0.addr), 64'h000);
    check("t6_addr0", 64'(imem1.addr), 64'h1F8);
    cyc(0, 0, 0, 0);
    check("t1_wait_noreq", 64'(imem0.req), 64'd0);
    cyc(0, 0, 0, 0);
    check("t1_valid_pc0", 64'({valid0, out0.curr_pc}), 64'({1'b1, 9'h000}));
    check("t1_addr4", 64'({imem0.req, imem0.addr}), 64'({1'b1, 9'h004}));
    check("t6_addr1", 64'(imem1.addr), 64'h1FC);
    cyc(0, 0, 0, 0);
    check("t1_bubble", 64'(valid0), 64'd0);
    cyc(0, 0, 0, 0);
    check("t1_valid_pc4", 64'({valid0, out0.curr_pc}), 64'({1'b1, 9'h004}));
    check("t1_addr8", 64'(imem0.addr), 64'h008);
    check("t6_wrap", 64'({imem1.req, imem1.addr}), 64'({1'b1, 9'h000}));

    // Stall while the response for 0x008 arrives, held 3 cycles.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("t2_hold_noreq", 64'(imem0.req), 64'd0);
    cyc(1, 0, 0, 0);
    check("t2_hold_noreq2", 64'(imem0.req), 64'd0);
    check("t2_hold_ifid", 64'({valid0, out0.curr_pc}), 64'({1'b0, 9'h004}));
    cyc(0, 0, 0, 0);
    check("t2_release_noreq", 64'(imem0.req), 64'd0);
    cyc(0, 0, 0, 0);
    check("t2_skid_out", 64'({valid0, out0}), 64'({1'b1, 9'h008, mem_word(9'h008)}));
    check("t2_next_addr", 64'({imem0.req, imem0.addr}), 64'({1'b1, 9'h00C}));

    // Redirect while waiting on a slow response for 0x010.
    cyc(0, 0, 0, 0);
    lat = 3;
    cyc(0, 0, 0, 0);
    check("t3_addr10", 64'({imem0.req, imem0.addr}), 64'({1'b1, 9'h010}));
    lat = 1;
    cyc(0, 1, 9'h040, 0);
    check("t3_redir_noreq", 64'(imem0.req), 64'd0);
    cyc(0, 0, 0, 0);
    check("t3_discard_noreq", 64'({imem0.req, valid0}), 64'd0);
    cyc(0, 0, 0, 0);
    check("t3_late_rvalid_noreq", 64'(imem0.req), 64'd0);
    cyc(0, 0, 0, 0);
    check("t3_target", 64'({imem0.req, imem0.addr, valid0}), 64'({1'b1, 9'h040, 1'b0}));
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("t3_target_ifid", 64'({valid0, out0.curr_pc}), 64'({1'b1, 9'h040}));

    // Redirect and halt together: redirect wins.
    cyc(0, 1, 9'h080, 1);
    cyc(0, 0, 0, 0);
    check("t4_redir_addr", 64'({imem0.req, imem0.addr}), 64'({1'b1, 9'h080}));
    check("t4_not_halted", 64'(halted0), 64'd0);
    cyc(0, 0, 0, 0);
    lat = 2;
    cyc(0, 0, 0, 0);
    check("t4_ifid", 64'({valid0, out0.curr_pc}), 64'({1'b1, 9'h080}));
    lat = 1;

    // Halt while waiting: response dropped, fetch stops for good.
    cyc(0, 0, 0, 1);
    check("t5_halt_noreq", 64'(imem0.req), 64'd0);
    cyc(0, 0, 0, 0);
    check("t5_discard_noreq", 64'(imem0.req), 64'd0);
    cyc(0, 0, 0, 0);
    check("t5_halted", 64'({halted0, imem0.req, valid0}), 64'({1'b1, 1'b0, 1'b0}));
    for (int i = 0; i < 12; i++) begin
      cyc(1'($urandom), 1'($urandom), 9'($urandom) & 9'h1FC, 1'($urandom));
      check("t5_stays_halted", 64'({halted0, imem0.req, valid0}), 64'({1'b1, 1'b0, 1'b0}));
    end

    // Reset in the middle of a request.
    rst_n = 1'b0;
    clear_model();
    release_reset();
    lat = 3;
    cyc(0, 0, 0, 0);
    check("t6_restart_addr", 64'({imem1.req, imem1.addr}), 64'({1'b1, 9'h1F8}));
    cyc(0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_rst", 64'({imem0.req, imem1.req, valid0, valid1, halted1}), 64'd0);
    check("t6_async_rst_out", 64'(out1), 64'd0);
    clear_model();
    lat = 1;
    release_reset();
    cyc(0, 0, 0, 0);
    check("t6_rst_again_addr", 64'({imem1.req, imem1.addr}), 64'({1'b1, 9'h1F8}));
    check("t6_rst_again_addr0", 64'({imem0.req, imem0.addr}), 64'({1'b1, 9'h000}));

    // Randomized stall/redirect/latency traffic checked against the stream model.
    n_deliv = 0;
    for (int i = 0; i < 600; i++) begin
      lat = $urandom_range(1, 3);
      cyc(($urandom % 4) == 0, ($urandom % 12) == 0, 9'($urandom) & 9'h1FC, 1'b0);
    end
    check("rand_progress", 64'(n_deliv > 60), 64'd1);

    // Final halt under random stall, then redirects must not restart fetch.
    cyc(1'($urandom), 0, 0, 1);
    check("rand_halt_noreq", 64'(imem0.req), 64'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'($urandom), 0, 0, 0);
      check("rand_halt_drain_noreq", 64'(imem0.req), 64'd0);
    end
    check("rand_halted", 64'(halted0), 64'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'($urandom), 1'($urandom), 9'($urandom) & 9'h1FC, 0);
      check("rand_halt_sticky", 64'({halted0, imem0.req}), 64'({1'b1, 1'b0}));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
